keycode_action_decoder: RTL and testbench

//  Turns raw USB keycode words from the MicroBlaze GPIO into per-action game events for the Tetris core.

---
 rtl/keycode_action_decoder_if.sv | 13 +
 rtl/keycode_action_decoder.sv | 168 ++++++++++++++++
 tb/tb_keycode_action_decoder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/keycode_action_decoder_if.sv
// Event stream from the keycode decoder to the game logic.
// A transfer happens on a rising clock edge where event_valid && event_ready; the producer holds
// event_action stable while event_valid is high, and the consumer may drive event_ready freely.
interface keycode_action_decoder_if #(
    parameter int AW = 3
);
    logic          event_valid;
    logic [AW-1:0] event_action;
    logic          event_ready;

    modport master (output event_valid, output event_action, input event_ready);
    modport slave  (input event_valid, input event_action, output event_ready);
endinterface

// File: rtl/keycode_action_decoder.sv
// Maps USB keycode slots to game actions, generates press and DAS/ARR repeat pulses timed by
// vsync frame ticks, and queues the resulting action indices in a small event FIFO.
module keycode_action_decoder #(
    parameter int NUM_SLOTS   = 4,
    parameter int KEY_W       = 8,
    parameter int NUM_ACTIONS = 5,
    parameter logic [NUM_ACTIONS*KEY_W-1:0] ACTION_KEYS = {8'h2C, 8'h16, 8'h07, 8'h04, 8'h1A},
    parameter logic [NUM_ACTIONS-1:0]       REPEAT_MASK = 5'b00110,
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 2,
    parameter int CNT_W       = 6,
    parameter int FIFO_DEPTH  = 4,
    localparam int AW = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [NUM_SLOTS*KEY_W-1:0]   keycode_in,
    input  logic                         vsync,
    output logic [NUM_ACTIONS-1:0]       action_held,
    output logic [NUM_ACTIONS-1:0]       action_pulse,
    keycode_action_decoder_if.master     ev,
    output logic                         overflow,
    output logic [2*NUM_ACTIONS-1:0]     fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_FRAMES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'((ARR_FRAMES == 0) ? 0 : ARR_FRAMES - 1);

    logic [NUM_SLOTS*KEY_W-1:0] key_q;
    logic [NUM_ACTIONS-1:0]     match;
    logic                       vs_s1, vs_s2, vs_s3, tick;
    state_t                     state_q [NUM_ACTIONS];
    logic [CNT_W-1:0]           cnt_q   [NUM_ACTIONS];
    logic [NUM_ACTIONS-1:0]     pending;
    logic [AW-1:0]              mem     [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic                       full, empty, push, pop, found;
    logic [AW-1:0]              push_idx;

    // A zero table entry is an unused action and must never fire on empty slots.
    always_comb begin
        match = '0;
        for (int a = 0; a < NUM_ACTIONS; a++)
            for (int s = 0; s < NUM_SLOTS; s++)
                if (key_q[s*KEY_W +: KEY_W] == ACTION_KEYS[a*KEY_W +: KEY_W] &&
                    ACTION_KEYS[a*KEY_W +: KEY_W] != '0)
                    match[a] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_q <= '0;
            vs_s1 <= 1'b0;
            vs_s2 <= 1'b0;
            vs_s3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            key_q <= keycode_in;
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
            tick  <= vs_s3 & ~vs_s2;
        end
    end

    // Release wins over a same-cycle tick: the held check precedes the state case.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            action_held  <= '0;
            action_pulse <= '0;
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                state_q[a] <= IDLE;
                cnt_q[a]   <= '0;
            end
        end else begin
            action_held <= match;
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                action_pulse[a] <= 1'b0;
                if (!match[a]) begin
                    state_q[a] <= IDLE;
                    cnt_q[a]   <= '0;
                end else begin
                    case (state_q[a])
                        IDLE: begin
                            state_q[a]      <= DELAY;
                            cnt_q[a]        <= '0;
                            action_pulse[a] <= 1'b1;
                        end
                        DELAY: if (tick) begin
                            if (cnt_q[a] == DAS_LAST) begin
                                if (REPEAT_MASK[a] && ARR_FRAMES != 0) begin
                                    action_pulse[a] <= 1'b1;
                                    state_q[a]      <= REPEAT;
                                    cnt_q[a]        <= '0;
                                end
                            end else begin
                                cnt_q[a] <= cnt_q[a] + 1'b1;
                            end
                        end
                        REPEAT: if (tick) begin
                            if (cnt_q[a] == ARR_LAST) begin
                                action_pulse[a] <= 1'b1;
                                cnt_q[a]        <= '0;
                            end else begin
                                cnt_q[a] <= cnt_q[a] + 1'b1;
                            end
                        end
                        default: begin
                            state_q[a] <= IDLE;
                            cnt_q[a]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        fsm_state = '0;
        for (int a = 0; a < NUM_ACTIONS; a++)
            fsm_state[2*a +: 2] = state_q[a];
    end

    always_comb begin
        push_idx = '0;
        found    = 1'b0;
        for (int a = 0; a < NUM_ACTIONS; a++)
            if (pending[a] && !found) begin
                push_idx = AW'(a);
                found    = 1'b1;
            end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[PW-1], rd_ptr[PW-2:0]});
    assign pop   = !empty && ev.event_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = found && (!full || pop);

    assign ev.event_valid  = !empty;
    assign ev.event_action = mem[rd_ptr[PW-2:0]];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int a = 0; a < NUM_ACTIONS; a++) begin
                if (action_pulse[a] && pending[a])
                    overflow <= 1'b1;
                else if (action_pulse[a])
                    pending[a] <= 1'b1;
                else if (push && push_idx == AW'(a))
                    pending[a] <= 1'b0;
            end
            if (push) begin
                mem[wr_ptr[PW-2:0]] <= push_idx;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_keycode_action_decoder.sv
// Directed bench for keycode_action_decoder: event scoreboard plus pulse-count and timing checks.
module tb_keycode_action_decoder;
  localparam logic [2:0] NONE = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] keycode;
  logic        vsync;
  logic [4:0]  held, pulse;
  logic        ovf;
  logic [9:0]  fsm_state;

  logic [2:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int pcnt[5];
  int base;

  keycode_action_decoder_if #(.AW(3)) ev ();

  keycode_action_decoder dut (
    .Clk(clk), .Reset_n(rst_n), .keycode_in(keycode), .vsync(vsync),
    .action_held(held), .action_pulse(pulse), .ev(ev), .overflow(ovf),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    vsync = 1'b0;
    repeat (4) step();
    vsync = 1'b1;
    repeat (4) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    check("drain", exp_q.size(), 0);
    repeat (4) step();
  endtask

  // Scoreboard pop on every accepted event.
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst_n && ev.event_valid && ev.event_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : NONE;
      total++;
      assert (ev.event_action === e) else begin
        bad++;
        $error("FAIL event observed=%0d expected=%0d", ev.event_action, e);
      end
    end
  end

  always @(negedge clk)
    for (int a = 0; a < 5; a++) if (pulse[a] === 1'b1) pcnt[a]++;

  initial begin
    for (int a = 0; a < 5; a++) pcnt[a] = 0;
    rst_n = 1'b0; keycode = '0; vsync = 1'b1; ev.event_ready = 1'b1;
    repeat (3) step();
    check("rst_held", held, 0);
    check("rst_pulse", pulse, 0);
    check("rst_valid", ev.event_valid, 0);
    check("rst_action", ev.event_action, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Slot2 = 0x04: press, DAS 10 frames, ARR 2 frames, 40 frames held.
    base = pcnt[1];
    keycode = 32'h0004_0000;
    step();
    check("a_pulse_early", pulse, 0);
    step();
    check("a_pulse", pulse, 5'b00010);
    check("a_held", held, 5'b00010);
    exp_q.push_back(3'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(3'd1);
    for (int f = 1; f <= 40; f++) begin
      frame();
      if (f == 9)  check("a_das9", pcnt[1] - base, 1);
      if (f == 10) check("a_das10", pcnt[1] - base, 2);
      if (f == 40) check("a_f40", pcnt[1] - base, 17);
    end
    keycode = '0;
    drain();

    // W (0x1A) in slot0: one pulse, never repeats.
    base = pcnt[0];
    keycode = 32'h0000_001A;
    repeat (2) step();
    check("w_pulse", pulse, 5'b00001);
    exp_q.push_back(3'd0);
    repeat (30) frame();
    check("w_count", pcnt[0] - base, 1);
    keycode = '0;
    drain();

    // 0x04 and 0x07 together: FIFO receives 1 then 2 on consecutive cycles.
    keycode = 32'h0000_0704;
    repeat (2) step();
    check("dual_pulse", pulse, 5'b00110);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    step();
    check("dual_valid0", ev.event_valid, 0);
    step();
    check("dual_head1", {ev.event_valid, ev.event_action}, {1'b1, 3'd1});
    step();
    check("dual_head2", {ev.event_valid, ev.event_action}, {1'b1, 3'd2});
    keycode = '0;
    drain();

    // Five presses with consumer stalled, then a repeat press of the pending fifth key.
    ev.event_ready = 1'b0;
    begin
      logic [7:0] keys[5];
      keys = '{8'h1A, 8'h04, 8'h07, 8'h16, 8'h2C};
      for (int k = 0; k < 5; k++) begin
        keycode = {24'h0, keys[k]};
        repeat (2) step();
        keycode = '0;
        repeat (2) step();
        exp_q.push_back(3'(k));
      end
    end
    repeat (4) step();
    check("full_valid", ev.event_valid, 1);
    check("full_head", ev.event_action, 0);
    check("full_ovf0", ovf, 0);
    keycode = 32'h0000_002C;
    repeat (3) step();
    check("ovf_set", ovf, 1);
    keycode = '0;
    step();
    ev.event_ready = 1'b1;
    drain();
    check("ovf_sticky", ovf, 1);

    // 0x07 released after tick 9 of DAS, then re-pressed: DAS restarts.
    base = pcnt[2];
    keycode = 32'h0000_0007;
    repeat (2) step();
    exp_q.push_back(3'd2);
    repeat (9) frame();
    keycode = '0;
    repeat (3) step();
    repeat (5) frame();
    check("rel_count", pcnt[2] - base, 1);
    keycode = 32'h0000_0007;
    repeat (2) step();
    check("repress_pulse", pulse, 5'b00100);
    exp_q.push_back(3'd2);
    repeat (9) frame();
    check("repress_das9", pcnt[2] - base, 2);
    exp_q.push_back(3'd2);
    frame();
    check("repress_das10", pcnt[2] - base, 3);
    keycode = '0;
    drain();

    // Reset in the middle of repeating with 0x04 and 0x16 held.
    keycode = 32'h0000_1604;
    repeat (2) step();
    check("pre_rst_pulse", pulse, 5'b01010);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    repeat (12) frame();
    drain();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {held, pulse, ev.event_valid, ovf}, 0);
    repeat (3) step();
    check("mid_rst_fsm", fsm_state, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_early", pulse, 0);
    step();
    check("post_rst_pulse", pulse, 5'b01010);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd3);
    keycode = '0;
    drain();
    check("end_valid", ev.event_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
